// File: rtl/dmem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_stage_pkg
// Description : Shared constants for the JOIN_DDP data-memory stage. Holds
//               the packet field widths, the default stage geometry and the
//               FSM state encoding used by dmem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_stage_pkg;

    // Packet layout: {color, gen, dest, LR, BR, MF, CPY, C, Z, data}
    localparam int unsigned C_COLOR_W    = 3;
    localparam int unsigned C_GEN_W      = 8;
    localparam int unsigned C_DEST_W     = 8;
    localparam int unsigned C_FLAG_W     = 6;
    localparam int unsigned C_DATA_WIDTH = 16;
    localparam int unsigned C_ADDR_WIDTH = 8;
    localparam int unsigned C_PKT_WIDTH  = C_COLOR_W + C_GEN_W + C_DEST_W +
                                           C_FLAG_W + C_DATA_WIDTH;

    // FSM state encoding
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_READ = 2'd1;
    localparam logic [1:0] C_ST_OUT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_stage_if
// Description : Packet handshake bundle around the data-memory stage.
//               Upstream side : Send_in, Ack_out, PACKET_IN, LOAD_FLG,
//                               WRITE_EN, WRITE_DATA
//               Downstream    : Send_out, Ack_in, PACKET_OUT
//               modport slave  - the stage itself
//               modport master - the environment driving the stage
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_stage_if
    import dmem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int PKT_WIDTH  = C_PKT_WIDTH
);
    logic                  Send_in;
    logic                  Ack_out;
    logic [PKT_WIDTH-1:0]  PACKET_IN;
    logic                  LOAD_FLG;
    logic                  WRITE_EN;
    logic [DATA_WIDTH-1:0] WRITE_DATA;
    logic                  Send_out;
    logic                  Ack_in;
    logic [PKT_WIDTH-1:0]  PACKET_OUT;

    modport slave (
        input  Send_in, PACKET_IN, LOAD_FLG, WRITE_EN, WRITE_DATA, Ack_in,
        output Ack_out, Send_out, PACKET_OUT
    );

    modport master (
        output Send_in, PACKET_IN, LOAD_FLG, WRITE_EN, WRITE_DATA, Ack_in,
        input  Ack_out, Send_out, PACKET_OUT
    );

endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port synchronous RAM, DATA_WIDTH x 2**ADDR_WIDTH.
//               Write on i_we, registered read on i_re (one-cycle latency).
//               Contents are not reset.
//   clk      in  : clock
//   i_we     in  : write enable
//   i_re     in  : read enable
//   i_addr   in  : word address
//   i_wdata  in  : write data
//   o_rdata  out : registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic                  i_re,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    output logic      [DATA_WIDTH-1:0] o_rdata
);
    localparam int C_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : dmem_stage
// Description : JOIN_DDP data-memory access stage. Performs a load or store
//               against a local RAM using the packet data field as address,
//               then forwards the result packet downstream.
//   CLK   in  : clock, rising edge
//   MR_N  in  : asynchronous active-low master reset
//   bus   io  : dmem_stage_if.slave packet handshake
//   ERR   out : sticky out-of-range address flag (only with DMEM_BOUND_CHK_EN)
// Build option: DMEM_BOUND_CHK_EN - reject addresses whose upper data bits
//               are nonzero instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_stage
    import dmem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int PKT_WIDTH  = C_PKT_WIDTH
) (
    input  wire logic   CLK,
    input  wire logic   MR_N,
    dmem_stage_if.slave bus
`ifdef DMEM_BOUND_CHK_EN
    ,
    output logic        ERR
`endif
);
    localparam int C_HDR_W = PKT_WIDTH - DATA_WIDTH;

    logic [1:0]            r_state;
    logic [C_HDR_W-1:0]    r_in_hdr;
    logic                  r_in_oor;
    logic [PKT_WIDTH-1:0]  r_pkt_out;
    logic                  r_send_out;

    logic                  w_idle;
    logic                  w_capture;
    logic                  w_is_load;
    logic                  w_oor;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_idle    = (r_state == C_ST_IDLE);
    assign w_capture = w_idle & bus.Send_in;
    // Write wins when both flags are set, so a load needs WRITE_EN low.
    assign w_is_load = bus.LOAD_FLG & ~bus.WRITE_EN;

`ifdef DMEM_BOUND_CHK_EN
    assign w_oor = |bus.PACKET_IN[DATA_WIDTH-1:ADDR_WIDTH];
`else
    assign w_oor = 1'b0;
`endif

    // The RAM is addressed straight from PACKET_IN on the capture edge:
    // stores commit there, and loads start the read there so the data is
    // waiting in the RAM output register during READ.
    assign w_ram_we = w_capture & bus.WRITE_EN & ~w_oor;
    assign w_ram_re = w_capture & w_is_load & ~w_oor;

    dmem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (CLK),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (bus.PACKET_IN[ADDR_WIDTH-1:0]),
        .i_wdata (bus.WRITE_DATA),
        .o_rdata (w_ram_rdata)
    );

    // Only the header survives past capture: the data field of a load is
    // replaced by RAM data, and stores/pass-throughs are built on the edge.
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            r_state    <= C_ST_IDLE;
            r_in_hdr   <= '0;
            r_in_oor   <= 1'b0;
            r_pkt_out  <= '0;
            r_send_out <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (bus.Send_in) begin
                        r_in_hdr <= bus.PACKET_IN[PKT_WIDTH-1:DATA_WIDTH];
                        r_in_oor <= w_oor;
                        if (w_is_load) begin
                            r_state <= C_ST_READ;
                        end else begin
                            r_state    <= C_ST_OUT;
                            r_send_out <= 1'b1;
                            r_pkt_out  <= bus.WRITE_EN ?
                                {bus.PACKET_IN[PKT_WIDTH-1:DATA_WIDTH], bus.WRITE_DATA} :
                                bus.PACKET_IN;
                        end
                    end
                end
                C_ST_READ: begin
                    r_state    <= C_ST_OUT;
                    r_send_out <= 1'b1;
                    r_pkt_out  <= {r_in_hdr, (r_in_oor ? '0 : w_ram_rdata)};
                end
                C_ST_OUT: begin
                    if (bus.Ack_in) begin
                        r_state    <= C_ST_IDLE;
                        r_send_out <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= C_ST_IDLE;
                    r_send_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_BOUND_CHK_EN
    logic r_err;

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            r_err <= 1'b0;
        end else if (w_capture & w_oor & (bus.WRITE_EN | bus.LOAD_FLG)) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`endif

    // Gated by MR_N so the strobe also drops asynchronously during reset.
    assign bus.Ack_out    = MR_N & w_idle & bus.Send_in;
    assign bus.Send_out   = r_send_out;
    assign bus.PACKET_OUT = r_pkt_out;

endmodule
`default_nettype wire

// File: tb/tb_dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_stage
// Description : Self-checking bench for dmem_stage. Expected packets are
//               queued when a packet is driven and popped when Send_out rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_stage;

    logic clk = 1'b0;
    logic mr_n;
`ifdef DMEM_BOUND_CHK_EN
    logic err;
`endif

    always #5 clk = ~clk;

    dmem_stage_if #(.DATA_WIDTH(16), .PKT_WIDTH(41)) bus ();

    dmem_stage #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .PKT_WIDTH  (41)
    ) u_dut (
        .CLK  (clk),
        .MR_N (mr_n),
        .bus  (bus)
`ifdef DMEM_BOUND_CHK_EN
        ,
        .ERR  (err)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [40:0] sb_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] mk(input logic [5:0] fl, input logic [15:0] d);
        return {3'd5, 8'h3C, 8'hA7, fl, d};
    endfunction

    // Drive one packet, measure capture-to-Send_out latency, compare, retire.
    task automatic run_pkt(input string tag, input logic [40:0] pkt, input logic ld,
                           input logic we, input logic [15:0] wd, input int exp_lat,
                           input logic [40:0] exp_pkt);
        logic [40:0] e;
        int n;
        sb_q.push_back(exp_pkt);
        bus.PACKET_IN  = pkt;
        bus.LOAD_FLG   = ld;
        bus.WRITE_EN   = we;
        bus.WRITE_DATA = wd;
        bus.Send_in    = 1'b1;
        #1;
        check({tag, "_ack"}, 64'(bus.Ack_out), 64'd1);
        tick();
        bus.Send_in  = 1'b0;
        bus.LOAD_FLG = 1'b0;
        bus.WRITE_EN = 1'b0;
        n = 1;
        while (!bus.Send_out && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_pkt"}, 64'(bus.PACKET_OUT), 64'(e));
        end
        bus.Ack_in = 1'b1;
        tick();
        bus.Ack_in = 1'b0;
        check({tag, "_done"}, 64'(bus.Send_out), 64'd0);
    endtask

    initial begin
        logic [40:0] p1;
        logic [40:0] p2;
        logic [40:0] e;

        mr_n           = 1'b0;
        bus.Send_in    = 1'b1;
        bus.PACKET_IN  = '0;
        bus.LOAD_FLG   = 1'b0;
        bus.WRITE_EN   = 1'b0;
        bus.WRITE_DATA = '0;
        bus.Ack_in     = 1'b0;
        #2;
        check("rst_send_out", 64'(bus.Send_out), 64'd0);
        check("rst_ack_out", 64'(bus.Ack_out), 64'd0);
        check("rst_pkt_out", 64'(bus.PACKET_OUT), 64'd0);
`ifdef DMEM_BOUND_CHK_EN
        check("rst_err", 64'(err), 64'd0);
`endif
        bus.Send_in = 1'b0;
        tick();
        mr_n = 1'b1;
        tick();

        // Store then load at 0x0012
        run_pkt("stm12", mk(6'b000000, 16'h0012), 1'b0, 1'b1, 16'hBEEF, 1, mk(6'b000000, 16'hBEEF));
        run_pkt("ldm12", mk(6'b100001, 16'h0012), 1'b1, 1'b0, 16'h0000, 2, mk(6'b100001, 16'hBEEF));

        // Pass-through ADD result, C=1
        run_pkt("pass", mk(6'b000010, 16'h1234), 1'b0, 1'b0, 16'hFFFF, 1, mk(6'b000010, 16'h1234));

        // Backpressure: hold Ack_in low for 5 cycles with next packet waiting
        p1 = mk(6'b010000, 16'h7777);
        p2 = mk(6'b001000, 16'h0101);
        sb_q.push_back(p1);
        bus.PACKET_IN = p1;
        bus.Send_in   = 1'b1;
        tick();
        bus.PACKET_IN = p2;
        #1;
        check("bp_send_out", 64'(bus.Send_out), 64'd1);
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("bp_pkt_stable", 64'(bus.PACKET_OUT), 64'(e));
            check("bp_ack_out", 64'(bus.Ack_out), 64'd0);
            tick();
        end
        bus.Ack_in = 1'b1;
        tick();
        bus.Ack_in = 1'b0;
        #1;
        check("bp_idle", 64'(bus.Send_out), 64'd0);
        check("bp_next_ack", 64'(bus.Ack_out), 64'd1);
        sb_q.push_back(p2);
        tick();
        bus.Send_in = 1'b0;
        check("bp_next_send", 64'(bus.Send_out), 64'd1);
        e = sb_q.pop_front();
        check("bp_next_pkt", 64'(bus.PACKET_OUT), 64'(e));
        bus.Ack_in = 1'b1;
        tick();
        bus.Ack_in = 1'b0;

        // Both flags set: write wins, store latency
        run_pkt("both", mk(6'b000001, 16'h0005), 1'b1, 1'b1, 16'h00AA, 1, mk(6'b000001, 16'h00AA));
        run_pkt("ldm05", mk(6'b000000, 16'h0005), 1'b1, 1'b0, 16'h0000, 2, mk(6'b000000, 16'h00AA));

        // Address 0x0105: wraps, or is rejected with the bound check
        run_pkt("stm105", mk(6'b000100, 16'h0105), 1'b0, 1'b1, 16'h5A5A, 1, mk(6'b000100, 16'h5A5A));
`ifdef DMEM_BOUND_CHK_EN
        check("err_set", 64'(err), 64'd1);
        run_pkt("ldm05_chk", mk(6'b000000, 16'h0005), 1'b1, 1'b0, 16'h0000, 2, mk(6'b000000, 16'h00AA));
        run_pkt("ldm105_chk", mk(6'b000000, 16'h0105), 1'b1, 1'b0, 16'h0000, 2, mk(6'b000000, 16'h0000));
`else
        run_pkt("ldm05_wrap", mk(6'b000000, 16'h0005), 1'b1, 1'b0, 16'h0000, 2, mk(6'b000000, 16'h5A5A));
        run_pkt("ldm105_wrap", mk(6'b000000, 16'h0105), 1'b1, 1'b0, 16'h0000, 2, mk(6'b000000, 16'h5A5A));
`endif

        // Reset in the middle of a load
        bus.PACKET_IN = mk(6'b000000, 16'h0012);
        bus.LOAD_FLG  = 1'b1;
        bus.Send_in   = 1'b1;
        tick();
        bus.Send_in  = 1'b0;
        bus.LOAD_FLG = 1'b0;
        #2;
        mr_n = 1'b0;
        #1;
        check("mrst_send_out", 64'(bus.Send_out), 64'd0);
        check("mrst_pkt_out", 64'(bus.PACKET_OUT), 64'd0);
        bus.Send_in = 1'b1;
        #1;
        check("mrst_ack_out", 64'(bus.Ack_out), 64'd0);
`ifdef DMEM_BOUND_CHK_EN
        check("mrst_err", 64'(err), 64'd0);
`endif
        bus.Send_in = 1'b0;
        @(negedge clk);
        mr_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("mrst_no_out", 64'(bus.Send_out), 64'd0);
            tick();
        end
        // Committed store survives reset
        run_pkt("ldm12_post", mk(6'b000000, 16'h0012), 1'b1, 1'b0, 16'h0000, 2, mk(6'b000000, 16'hBEEF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_stage.md
# dmem_stage

Data-memory access stage of the JOIN_DDP pipeline, directly downstream of the function-processing (FP) stage. It receives the FP output packet with its `LOAD_FLG`, `WRITE_EN` and `WRITE_DATA` sidebands and performs the load or store against a local data memory, using the packet data field as the address. It then forwards a result packet to the next stage. Non-memory packets pass straight through with one cycle less latency.

## Interface
Parameters:
- `DATA_WIDTH`, 16: data field width; also the address field width.
- `ADDR_WIDTH`, 8: memory address bits; `DEPTH = 2**ADDR_WIDTH` words.
- `PKT_WIDTH`, 41: full packet width, laid out as {color(3), gen(8), dest(8), LR, BR, MF, CPY, C, Z, data(`DATA_WIDTH`)}.

Ports:
- `CLK` in 1: single clock, rising edge.
- `MR_N` in 1: master reset, asynchronous, active-low.
- `Send_in` in 1: upstream packet valid (level).
- `Ack_out` out 1: capture strobe to upstream.
- `PACKET_IN` in `PKT_WIDTH`: FP output packet. Data field = ALU result, which is the address for LDM/STM.
- `LOAD_FLG` in 1: packet is a load.
- `WRITE_EN` in 1: packet is a store.
- `WRITE_DATA` in `DATA_WIDTH`: store data.
- `Send_out` out 1: downstream packet valid.
- `Ack_in` in 1: downstream accept.
- `PACKET_OUT` out `PKT_WIDTH`: result packet.
- `ERR` out 1: sticky address error. Exists only with `DMEM_BOUND_CHK_EN`.

## Operation
- FSM states: IDLE, READ, OUT.
- IDLE:
  - `Ack_out = Send_in` (combinational; 0 in every other state).
  - On a clock edge with `Send_in=1`, capture `PACKET_IN`, `LOAD_FLG`, `WRITE_EN`, `WRITE_DATA` into the input register.
  - Next state is READ if `LOAD_FLG=1` and `WRITE_EN=0`; otherwise OUT.
- Store (`WRITE_EN=1`):
  - `mem[addr] <= WRITE_DATA` on the capture edge.
  - The packet is forwarded with its data field replaced by `WRITE_DATA`; this acts as a completion token.
  - `LOAD_FLG` is ignored when `WRITE_EN` is also set: write has priority and no read is performed.
- Load: READ issues a synchronous read of `mem[addr]`. The read data replaces the data field, and the FSM moves to OUT.
- Pass-through (neither flag set): the packet is forwarded unchanged.
- Address: `addr = data[ADDR_WIDTH-1:0]`. The upper data bits are ignored, so the address wraps modulo DEPTH, unless the bound check is enabled.
- OUT:
  - `Send_out=1` and `PACKET_OUT` is held stable.
  - On an edge with `Ack_in=1`, go to IDLE.
  - `Ack_in` sampled in any other state is ignored.
- Color, gen, dest, LR, BR, MF, CPY, C and Z are never modified.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset: state=IDLE, `Send_out=0`, `Ack_out=0`, `PACKET_OUT=0`, `ERR=0`, input register=0.
  - Reset asserted mid-operation aborts the packet immediately; no output is produced.
  - A store already committed on its capture edge remains in memory.
- Latency from capture edge E0 to `Send_out` high:
  - Pass-through and store: one cycle (high after E0).
  - Load: two cycles (high after E1).
- Throughput:
  - Pass-through and store: 1 packet per 2 cycles.
  - Load: 1 packet per 3 cycles.
  - Each figure assumes `Ack_in` is high on the first OUT cycle.
- Downstream backpressure: `Ack_in` held low keeps the block in OUT indefinitely. `Ack_out` stays 0 throughout, so upstream must hold `Send_in` and `PACKET_IN`.
- Upstream must drop `Send_in` or present the next packet in the cycle after `Ack_out`.

## Configuration
- `DMEM_BOUND_CHK_EN` defined:
  - A LDM/STM address with any nonzero bit in `data[DATA_WIDTH-1:ADDR_WIDTH]` is out of range.
  - Out-of-range store: the write is suppressed.
  - Out-of-range load: returns 0 and skips the memory read, but still passes through READ.
  - Either case sets `ERR` (sticky until reset).
- `DMEM_BOUND_CHK_EN` undefined: addresses wrap and the `ERR` port is absent.

## Structure
- Packet field widths, field slice macros and `PKT_WIDTH` go in the shared common_macro.vh / common_param.vh headers, next to the FP packet definitions.
- One sub-module, `dmem_ram`: single-port synchronous RAM with `DATA_WIDTH` x `DEPTH` words, write-enable, and 1-cycle registered read.
- The FSM, input register and output mux live in `dmem_stage`.

## Test plan
- Reset: drive `MR_N` low mid-load → all outputs 0 asynchronously; FSM in IDLE after release.
- Store then load: STM with addr=0x0012 and `WRITE_DATA`=0xBEEF → `PACKET_OUT` data=0xBEEF. Then LDM with addr=0x0012 → data=0xBEEF, with `Send_out` rising exactly 2 cycles after capture.
- Pass-through: ADD result packet with data=0x1234 and C=1 → identical packet out, with `Send_out` high 1 cycle after capture.
- Backpressure: hold `Ack_in`=0 for 5 cycles → `PACKET_OUT` stable and `Ack_out`=0 throughout. Then `Ack_in`=1 → IDLE, and the next packet is accepted in the following cycle.
- Simultaneous `LOAD_FLG`=`WRITE_EN`=1 with addr=0x0005 and data=0x00AA → memory written and output data=0x00AA with store latency.
- Address wrap and bound check, addr=0x0105:
  - Without the macro: the store writes `mem[0x05]`.
  - With the macro: `mem[0x05]` is unchanged, `ERR`=1, and a load from the same address returns 0.
